// File: rtl/cv32e40s_pkg.sv
// Shared types for the cv32e40s OBI data-side subsystem.
//   resp_tag_t : per-transfer response tag kept in order between grant and
//                response (is_err: out-of-window transfer answered locally,
//                is_store: memory write, response carries no read data).
package cv32e40s_pkg;

  typedef struct packed {
    logic is_err;
    logic is_store;
  } resp_tag_t;

endpackage

// File: rtl/cv32e40s_obi_resp_fifo.sv
// In-order tag FIFO for outstanding OBI data transfers.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (flushes contents)
//   push, tag    : write one tag at the tail
//   pop          : drop the head entry
//   full, empty  : occupancy flags
//   head         : tag at the head (valid when !empty)
//   count        : number of stored entries
module cv32e40s_obi_resp_fifo
  import cv32e40s_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  resp_tag_t     tag,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output resp_tag_t     head,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_tag_t       store_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   cnt_q;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_next(wptr_q);
      if (pop)  rptr_q <= ptr_next(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) store_q[wptr_q] <= tag;
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = store_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/cv32e40s_obi_data_responder.sv
// OBI data-interface responder: decodes one memory window, forwards in-window
// transfers to a backing memory port and returns in-order OBI responses;
// out-of-window transfers are answered locally with err_o.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i : OBI request channel
//   rvalid_o/rdata_o/err_o        : OBI response channel (never stalled)
//   mem_req_o/mem_gnt_i/mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o : memory request
//   mem_rvalid_i/mem_rdata_i      : memory response, in order
//   protocol_err_o                : memory response with no memory entry at head
module cv32e40s_obi_data_responder
  import cv32e40s_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        protocol_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   offset;
  logic          in_range;
  logic          fifo_full;
  logic          fifo_empty;
  resp_tag_t     head;
  resp_tag_t     push_tag;
  logic [CW-1:0] fifo_count;
  logic          head_err;
  logic          head_mem;
  logic          pop;

  // Wrapping subtraction makes addresses below MEM_BASE fall out of range.
  assign offset   = addr_i - MEM_BASE;
  assign in_range = (offset < MEM_SIZE);

  // Full is taken from the registered count only, so a same-cycle pop never
  // reaches the grant combinationally.
  assign mem_req_o = req_i && in_range && !fifo_full;
  assign gnt_o     = in_range ? (mem_req_o && mem_gnt_i) : (req_i && !fifo_full);

  assign mem_addr_o  = offset >> 2;
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  assign push_tag.is_err   = !in_range;
  assign push_tag.is_store = we_i;

  cv32e40s_obi_resp_fifo #(.DEPTH(DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_o),
    .tag   (push_tag),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head),
    .count (fifo_count)
  );

  assign head_err = !fifo_empty && head.is_err;
  assign head_mem = !fifo_empty && !head.is_err;

  assign rvalid_o       = head_err || (head_mem && mem_rvalid_i);
  assign err_o          = head_err;
  assign rdata_o        = (head_mem && mem_rvalid_i && !head.is_store) ? mem_rdata_i : 32'h0;
  assign pop            = rvalid_o;
  // Stray memory responses are flagged and dropped, never forwarded.
  assign protocol_err_o = mem_rvalid_i && !head_mem;

  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_cv32e40s_obi_data_responder.sv
module tb_cv32e40s_obi_data_responder;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] SIZE  = 32'h0001_0000;

  logic        clk, rst;
  logic        req_i, gnt_o, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        protocol_err_o;

  cv32e40s_obi_data_responder #(.DEPTH(DEPTH), .MEM_BASE(BASE), .MEM_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .protocol_err_o(protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: window membership from plain 64-bit bounds, memory
  // content as a fixed function of the word offset.
  function automatic bit model_in_range(input logic [31:0] a);
    longint unsigned aa, lo, hi;
    aa = longint'(a); lo = longint'(BASE); hi = lo + longint'(SIZE);
    return (aa >= lo) && (aa < hi);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] woff);
    return (woff * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  typedef struct { int ready; logic [31:0] data; } mrsp_t;
  exp_t  exp_q[$];
  mrsp_t mem_q[$];

  bit          mon_en = 0;
  int          cyc = 0;
  bit          pend = 0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  logic [3:0]  p_be;

  // Scoreboard monitor: queue holds entries granted in earlier cycles, so its
  // size is the expected outstanding count for this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() >= DEPTH) begin
        check("full_gnt", {63'd0, gnt_o}, 64'd0);
        check("full_mreq", {63'd0, mem_req_o}, 64'd0);
      end else if (req_i) begin
        if (model_in_range(addr_i)) begin
          check("in_mreq", {63'd0, mem_req_o}, 64'd1);
          check("in_gnt", {63'd0, gnt_o}, {63'd0, mem_gnt_i});
        end else begin
          check("out_mreq", {63'd0, mem_req_o}, 64'd0);
          check("out_gnt", {63'd0, gnt_o}, 64'd1);
        end
      end else begin
        check("idle_gnt", {63'd0, gnt_o}, 64'd0);
      end
      if (exp_q.size() == 0) begin
        check("empty_rvalid", {63'd0, rvalid_o}, 64'd0);
        check("empty_perr", {63'd0, protocol_err_o}, {63'd0, mem_rvalid_i});
      end else if (exp_q[0].err) begin
        check("err_rvalid", {63'd0, rvalid_o}, 64'd1);
        check("err_err", {63'd0, err_o}, 64'd1);
        check("err_rdata", {32'd0, rdata_o}, 64'd0);
        void'(exp_q.pop_front());
      end else begin
        check("mem_rvalid", {63'd0, rvalid_o}, {63'd0, mem_rvalid_i});
        check("mem_perr", {63'd0, protocol_err_o}, 64'd0);
        if (rvalid_o) begin
          check("mem_err", {63'd0, err_o}, 64'd0);
          check("mem_rdata", {32'd0, rdata_o}, {32'd0, exp_q[0].rdata});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One random cycle: OBI master (holds request until granted) + memory model.
  task automatic rnd_cycle(input bit new_en);
    int k;
    logic [31:0] woff;
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    if (!pend && new_en && $urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, 11);
      if (k < 6)       p_addr = BASE + $urandom_range(0, SIZE / 4 - 1) * 4;
      else if (k == 6) p_addr = BASE + SIZE - 4;
      else if (k < 9)  p_addr = 32'h0002_0000 + ($urandom & 32'h0000_FFFC);
      else if (k == 9) p_addr = BASE + SIZE;
      else if (k == 10) p_addr = 32'hFFFF_FFFC;
      else             p_addr = 32'h8000_0000 | $urandom;
      p_we = 1'($urandom_range(0, 1));
      p_be = 4'($urandom);
      p_wdata = $urandom;
      pend = 1;
    end
    req_i = pend; addr_i = p_addr; we_i = p_we; be_i = p_be; wdata_i = p_wdata;
    mem_gnt_i = ($urandom_range(0, 2) != 0);
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && exp_q.size() > 0 && !exp_q[0].err
        && $urandom_range(0, 3) != 0) begin
      mem_rvalid_i = 1; mem_rdata_i = mem_q[0].data;
    end else begin
      mem_rvalid_i = 0; mem_rdata_i = $urandom;
    end
    @(negedge clk); #2;
    if (mem_rvalid_i) void'(mem_q.pop_front());
    if (mem_req_o && mem_gnt_i) begin
      check("maddr", {32'd0, mem_addr_o}, {32'd0, (p_addr - BASE) / 4});
      check("mwe_be", {59'd0, mem_we_o, mem_be_o}, {59'd0, p_we, p_be});
      check("mwdata", {32'd0, mem_wdata_o}, {32'd0, p_wdata});
      mem_q.push_back('{cyc + $urandom_range(1, 4), p_we ? $urandom : mem_word(mem_addr_o)});
    end
    if (gnt_o) begin
      woff = (p_addr - BASE) / 4;
      e.err = !model_in_range(p_addr);
      e.rdata = (e.err || p_we) ? 32'h0 : mem_word(woff);
      exp_q.push_back(e);
      pend = 0;
    end
  endtask

  task automatic drv(input logic rq, input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic mg, input logic mv, input logic [31:0] md);
    @(posedge clk); #1;
    req_i = rq; addr_i = a; we_i = w; be_i = b; wdata_i = 32'hA5A5_0000;
    mem_gnt_i = mg; mem_rvalid_i = mv; mem_rdata_i = md;
    #3;
  endtask

  initial begin
    rst = 1; req_i = 0; addr_i = 0; we_i = 0; be_i = 0; wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #4;
    check("rst_outs", {58'd0, gnt_o, rvalid_o, err_o, mem_req_o, protocol_err_o, 1'b0},
          64'd0);
    check("rst_rdata", {32'd0, rdata_o}, 64'd0);
    @(posedge clk); #1; rst = 0;

    // Read 0x10, latency 1.
    drv(1, 32'h10, 0, 4'hF, 1, 0, 0);
    check("rd_gnt", {62'd0, gnt_o, mem_req_o}, 64'd3);
    check("rd_maddr", {32'd0, mem_addr_o}, 64'd4);
    drv(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("rd_rsp", {30'd0, rvalid_o, err_o, rdata_o}, {30'd0, 2'b10, 32'hDEAD_BEEF});

    // Out-of-range read.
    drv(1, 32'h0002_0000, 0, 4'hF, 0, 0, 0);
    check("oor_gnt", {62'd0, gnt_o, mem_req_o}, 64'd2);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("oor_rsp", {30'd0, rvalid_o, err_o, rdata_o}, {30'd0, 2'b11, 32'h0});

    // Store to 0x20, be 0011.
    drv(1, 32'h20, 1, 4'b0011, 1, 0, 0);
    check("st_mem", {23'd0, gnt_o, mem_we_o, mem_be_o, 3'd0, mem_addr_o},
          {23'd0, 1'b1, 1'b1, 4'b0011, 3'd0, 32'd8});
    drv(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    check("st_rsp", {30'd0, rvalid_o, err_o, rdata_o}, {30'd0, 2'b10, 32'h0});

    // Latency-4 read followed by out-of-range write: error waits behind it.
    drv(1, 32'h40, 0, 4'hF, 1, 0, 0);
    check("ord_g0", {63'd0, gnt_o}, 64'd1);
    drv(1, 32'h0003_0000, 1, 4'hF, 0, 0, 0);
    check("ord_g1", {63'd0, gnt_o}, 64'd1);
    for (int i = 2; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0);
      check("ord_wait", {63'd0, rvalid_o}, 64'd0);
    end
    drv(0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
    check("ord_c4", {30'd0, rvalid_o, err_o, rdata_o}, {30'd0, 2'b10, 32'h0BAD_F00D});
    drv(0, 0, 0, 0, 0, 0, 0);
    check("ord_c5", {62'd0, rvalid_o, err_o}, 64'd3);

    // Full: third request waits until the cycle after the first pop.
    drv(1, 32'h100, 0, 4'hF, 1, 0, 0);
    check("full_g0", {63'd0, gnt_o}, 64'd1);
    drv(1, 32'h104, 0, 4'hF, 1, 0, 0);
    check("full_g1", {63'd0, gnt_o}, 64'd1);
    drv(1, 32'h108, 0, 4'hF, 1, 0, 0);
    check("full_g2", {62'd0, gnt_o, mem_req_o}, 64'd0);
    drv(1, 32'h108, 0, 4'hF, 1, 1, 32'h1);
    check("full_pop", {62'd0, gnt_o, rvalid_o}, 64'd1);
    drv(1, 32'h108, 0, 4'hF, 1, 0, 0);
    check("full_reopen", {63'd0, gnt_o}, 64'd1);
    drv(0, 0, 0, 0, 0, 1, 32'h2);
    check("full_d1", {63'd0, rvalid_o}, 64'd1);
    drv(0, 0, 0, 0, 0, 1, 32'h3);
    check("full_d2", {30'd0, rvalid_o, err_o, rdata_o}, {30'd0, 2'b10, 32'h3});

    // Reset with two reads outstanding, then a stray memory response.
    drv(1, 32'h200, 0, 4'hF, 1, 0, 0);
    drv(1, 32'h204, 0, 4'hF, 1, 0, 0);
    @(posedge clk); #1; rst = 1; req_i = 0; mem_gnt_i = 0;
    @(posedge clk); #1; rst = 0;
    drv(0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
    check("rst_stray", {62'd0, rvalid_o, protocol_err_o}, 64'd1);
    drv(1, 32'h0002_0004, 0, 4'hF, 0, 0, 0);
    check("rst_empty_gnt", {62'd0, gnt_o, protocol_err_o}, 64'd2);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("rst_empty_rsp", {62'd0, rvalid_o, err_o}, 64'd3);

    // Randomized phase under the scoreboard.
    @(posedge clk); #1;
    req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    exp_q.delete(); mem_q.delete(); pend = 0;
    mon_en = 1;
    for (int i = 0; i < 3000; i++) rnd_cycle(1);
    begin
      int budget = 300;
      while ((pend || exp_q.size() > 0) && budget > 0) begin
        rnd_cycle(0);
        budget--;
      end
      check("drain_timeout", {63'd0, (pend || exp_q.size() > 0)}, 64'd0);
    end
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
